display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Time-multiplexes one shared hex->7-segment decoder across NUM_DIGITS common-anode digits.
//  - Drives the decoder's 4-bit input and one active-low anode enable per digit.
//  - Inserts a blanking gap between digits to suppress ghosting.
//  - Double-buffers digit values so that updates land only on frame boundaries.
//  - Sits between the switch/counter datapath and the board-level decoder and segment pins.
// PARAMETERS
//  NUM_DIGITS    2      digits scanned; legal range 2..8
//  DIGIT_CYCLES  24000  clk cycles each digit is lit; must be >= 1
//  BLANK_CYCLES  240    clk cycles with all anodes off after each digit; must be >= 1
// PORTS
//  clk          in   1             system clock; all logic is on the rising edge
//  reset_n      in   1             synchronous, active-low reset
//  en           in   1             scan enable; 0 = display dark
//  digits_in    in   4*NUM_DIGITS  packed nibbles; digit k = digits_in[4k+3:4k]; digit 0 = rightmost
//  load         in   1             1-cycle strobe: capture digits_in into the shadow register
//  dec_s        out  4             nibble to the shared decoder input
//  an           out  NUM_DIGITS    anode enables, active-low, at most one low
//  frame_start  out  1             1-cycle pulse on the first lit cycle of digit 0
// BEHAVIOUR
//  - All outputs are registered. They change on the same edge as the state.
//  - Reset (reset_n=0 at an edge):
//      state=BLANK, cnt=0, idx=NUM_DIGITS-1, an=all 1, dec_s=0, frame_start=0.
//      shadow=0, active=0, pending=0.
//  - FSM states:
//      SHOW:  an[idx]=0, all other anodes 1, dec_s=active[idx].
//             After DIGIT_CYCLES cycles -> BLANK with cnt=0.
//      BLANK: an=all 1; dec_s holds its value.
//             After BLANK_CYCLES cycles -> SHOW with idx=(idx==NUM_DIGITS-1)?0:idx+1 and cnt=0.
//  - Frame boundary is the BLANK->SHOW transition into idx 0.
//      If pending=1: active<=shadow and pending<=0, with the new value visible on that same cycle.
//      frame_start=1 for exactly that cycle.
//  - First lit cycle after reset release is cycle BLANK_CYCLES (digit 0).
//    Frame period = NUM_DIGITS*(DIGIT_CYCLES+BLANK_CYCLES).
//  - load=1: shadow<=digits_in and pending<=1.
//      Repeated loads within one frame: last one wins.
//      load on the same cycle as a frame boundary: active<=digits_in directly (bypass), pending<=0.
//  - en=0: next edge forces the reset state for state, cnt, idx and outputs.
//      shadow, active and pending are retained. load is still accepted.
//      en 0->1 resumes exactly as after reset release.
//  - reset_n=0 mid-SHOW or mid-BLANK: the reset state applies at the next edge. No partial slot completes.
//  - Width rules:
//      cnt width = $clog2(max(DIGIT_CYCLES,BLANK_CYCLES)).
//      idx width = $clog2(NUM_DIGITS), minimum 1.
//      idx wraps at NUM_DIGITS-1, never at the power of 2.
//  - Invariant: an never has more than one bit low. an is all 1 in every BLANK cycle.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - In SHOW, an[idx] is held 1 when active[idx]==0 and every higher digit of active is 0.
//    - Digit 0 is always lit. Slot timing, dec_s and frame_start are unchanged.
//  LEADING_ZERO_BLANK_EN undefined:
//    - Every digit is lit in its SHOW slot, including leading zeros.
// TESTING (bench: NUM_DIGITS=2, DIGIT_CYCLES=4, BLANK_CYCLES=1; cycle 0 = first edge after reset release)
//  1. Reset: hold reset_n=0 for 3 cycles -> an=2'b11, dec_s=0, frame_start=0 throughout.
//  2. Scan: load digits_in=8'hA5 during reset, then release ->
//       cycle 0: an=11.
//       cycles 1-4: an=10, dec_s=5; frame_start=1 at cycle 1 only.
//       cycle 5: an=11.
//       cycles 6-9: an=01, dec_s=A.
//       cycle 11: frame repeats.
//  3. Frame-aligned update: load=1 with 8'h3C at cycle 7 -> dec_s=A until cycle 9; cycle 11 dec_s=C; cycle 16 dec_s=3.
//  4. Boundary bypass: load=1 with 8'h7E exactly at cycle 11 -> dec_s=E from cycle 11; pending=0.
//       Also: a second load at cycle 12 is not shown before cycle 21.
//  5. en=0 at cycle 3 for 2 cycles -> an=11 from cycle 4; after re-enable, BLANK for 1 cycle, then digit 0 with frame_start=1.
//  6. LEADING_ZERO_BLANK_EN with 8'h05 -> digit 1 slot has an=11; digit 0 slot has an=10.
//       Without the macro, the digit 1 slot has an=01 and dec_s=0.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIGITS common-anode digits through one shared hex decoder, with blanking gaps
// and frame-aligned double buffering. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 2,
  parameter int DIGIT_CYCLES = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic [3:0]              dec_s,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                         state, state_nx;
  logic [CW-1:0]                  cnt, cnt_nx;
  logic [IW-1:0]                  idx, idx_nx;
  logic [NUM_DIGITS-1:0][3:0]     din, shadow, shadow_nx, active, active_nx;
  logic                           pending, pending_nx;
  logic [NUM_DIGITS-1:0]          an_nx;
  logic [3:0]                     dec_nx;
  logic                           fs_nx;
  logic                           boundary;
  logic [NUM_DIGITS-1:0]          lead_zero;
  logic                           zacc;

  assign din = digits_in;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    idx_nx     = idx;
    boundary   = 1'b0;
    shadow_nx  = shadow;
    active_nx  = active;
    pending_nx = pending;
    an_nx      = '1;
    dec_nx     = dec_s;
    fs_nx      = 1'b0;
    lead_zero  = '0;
    zacc       = 1'b1;

    if (!en) begin
      state_nx = BLANK;
      cnt_nx   = '0;
      idx_nx   = IDX_LAST;
      dec_nx   = 4'h0;
    end else begin
      case (state)
        SHOW: if (cnt == DIG_LAST) begin
          state_nx = BLANK;
          cnt_nx   = '0;
        end
        default: if (cnt == BLK_LAST) begin
          state_nx = SHOW;
          cnt_nx   = '0;
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
          boundary = (idx_nx == '0);
        end
      endcase
    end

    if (load) begin
      shadow_nx  = din;
      pending_nx = 1'b1;
    end
    // A load coinciding with the frame boundary goes straight to the live buffer.
    if (boundary) begin
      if (load) begin
        active_nx  = din;
        pending_nx = 1'b0;
      end else if (pending) begin
        active_nx  = shadow;
        pending_nx = 1'b0;
      end
    end

    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zacc         = zacc && (active_nx[i] == 4'h0);
      lead_zero[i] = zacc;
    end

    if (en && state_nx == SHOW) begin
      an_nx[idx_nx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_nx != '0 && lead_zero[idx_nx]) an_nx[idx_nx] = 1'b1;
`endif
      dec_nx = active_nx[idx_nx];
      fs_nx  = boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= BLANK;
      cnt         <= '0;
      idx         <= IDX_LAST;
      an          <= '1;
      dec_s       <= 4'h0;
      frame_start <= 1'b0;
      shadow      <= '0;
      active      <= '0;
      pending     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      an          <= an_nx;
      dec_s       <= dec_nx;
      frame_start <= fs_nx;
      shadow      <= shadow_nx;
      active      <= active_nx;
      pending     <= pending_nx;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Table-driven bench for display_scan_ctrl (2 digits, 4 lit cycles, 1 blank cycle).
module tb_display_scan_ctrl;
  localparam int ND = 2;
  localparam int DC = 4;
  localparam int BC = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b1;
  logic          load = 1'b0;
  logic [4*ND-1:0] digits_in = '0;
  logic [3:0]    dec_s;
  logic [ND-1:0] an;
  logic          frame_start;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .digits_in(digits_in), .load(load),
    .dec_s(dec_s), .an(an), .frame_start(frame_start)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] din;
    logic [1:0] an;
    logic [3:0] dec;
    logic       fs;
  } vec_t;

  typedef struct {
    logic [1:0] an;
    logic [3:0] dec;
    logic       fs;
    int         row;
  } exp_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [1:0] LZ_AN = 2'b11;
`else
  localparam logic [1:0] LZ_AN = 2'b01;
`endif

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic void add(logic r, logic e, logic l, logic [7:0] d,
                              logic [1:0] a, logic [3:0] s, logic f);
    vec_t v;
    v.rst_n = r; v.en = e; v.load = l; v.din = d; v.an = a; v.dec = s; v.fs = f;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Common opening: reset rows, then load 8'hA5 on the release edge and run cycles 1..10.
  function automatic void open_a5(int nrst);
    for (int i = 0; i < nrst; i++) add(0, 1, 0, 8'h00, 2'b11, 4'h0, 0);
    add(1, 1, 1, 8'hA5, 2'b10, 4'h5, 1);
    for (int i = 2; i <= 4; i++) add(1, 1, 0, 8'h00, 2'b10, 4'h5, 0);
    add(1, 1, 0, 8'h00, 2'b11, 4'h5, 0);
  endfunction

  int cyc;
  int period;

  initial begin
    // Scan, then a mid-frame load that lands on the next frame.
    open_a5(3);
    add(1, 1, 0, 8'h00, 2'b01, 4'hA, 0);
    add(1, 1, 1, 8'h3C, 2'b01, 4'hA, 0);
    add(1, 1, 0, 8'h00, 2'b01, 4'hA, 0);
    add(1, 1, 0, 8'h00, 2'b01, 4'hA, 0);
    add(1, 1, 0, 8'h00, 2'b11, 4'hA, 0);
    add(1, 1, 0, 8'h00, 2'b10, 4'hC, 1);
    for (int i = 12; i <= 14; i++) add(1, 1, 0, 8'h00, 2'b10, 4'hC, 0);
    add(1, 1, 0, 8'h00, 2'b11, 4'hC, 0);
    add(1, 1, 0, 8'h00, 2'b01, 4'h3, 0);

    // Boundary bypass, then a load just after the boundary waits a full frame.
    open_a5(1);
    for (int i = 6; i <= 9; i++) add(1, 1, 0, 8'h00, 2'b01, 4'hA, 0);
    add(1, 1, 0, 8'h00, 2'b11, 4'hA, 0);
    add(1, 1, 1, 8'h7E, 2'b10, 4'hE, 1);
    add(1, 1, 1, 8'h12, 2'b10, 4'hE, 0);
    add(1, 1, 0, 8'h00, 2'b10, 4'hE, 0);
    add(1, 1, 0, 8'h00, 2'b10, 4'hE, 0);
    add(1, 1, 0, 8'h00, 2'b11, 4'hE, 0);
    for (int i = 16; i <= 19; i++) add(1, 1, 0, 8'h00, 2'b01, 4'h7, 0);
    add(1, 1, 0, 8'h00, 2'b11, 4'h7, 0);
    add(1, 1, 0, 8'h00, 2'b10, 4'h2, 1);
    add(1, 1, 0, 8'h00, 2'b10, 4'h2, 0);

    // Disable for two cycles mid-SHOW; a load while dark is still taken.
    add(0, 1, 0, 8'h00, 2'b11, 4'h0, 0);
    add(1, 1, 1, 8'hA5, 2'b10, 4'h5, 1);
    add(1, 1, 0, 8'h00, 2'b10, 4'h5, 0);
    add(1, 1, 0, 8'h00, 2'b10, 4'h5, 0);
    add(1, 0, 0, 8'h00, 2'b11, 4'h0, 0);
    add(1, 0, 1, 8'h66, 2'b11, 4'h0, 0);
    add(1, 1, 0, 8'h00, 2'b10, 4'h6, 1);
    add(1, 1, 0, 8'h00, 2'b10, 4'h6, 0);

    // Leading zero in digit 1, then reset mid-SHOW clears the buffers.
    add(0, 1, 0, 8'h00, 2'b11, 4'h0, 0);
    add(1, 1, 1, 8'h05, 2'b10, 4'h5, 1);
    for (int i = 2; i <= 4; i++) add(1, 1, 0, 8'h00, 2'b10, 4'h5, 0);
    add(1, 1, 0, 8'h00, 2'b11, 4'h5, 0);
    add(1, 1, 0, 8'h00, LZ_AN, 4'h0, 0);
    add(1, 1, 0, 8'h00, LZ_AN, 4'h0, 0);
    add(0, 1, 0, 8'h00, 2'b11, 4'h0, 0);
    add(1, 1, 0, 8'h00, 2'b10, 4'h0, 1);
    add(1, 1, 0, 8'h00, 2'b10, 4'h0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      exp_t x;
      @(negedge clk);
      reset_n   = vecs[i].rst_n;
      en        = vecs[i].en;
      load      = vecs[i].load;
      digits_in = vecs[i].din;
      e.an = vecs[i].an; e.dec = vecs[i].dec; e.fs = vecs[i].fs; e.row = i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      check($sformatf("row%0d an", x.row), int'(an), int'(x.an));
      check($sformatf("row%0d dec_s", x.row), int'(dec_s), int'(x.dec));
      check($sformatf("row%0d frame_start", x.row), int'(frame_start), int'(x.fs));
      check($sformatf("row%0d an_onehot", x.row), int'($countones(~an) <= 1), 1);
    end

    // Free-running: frame_start period must be ND*(DC+BC) cycles.
    @(negedge clk);
    load = 1'b0; en = 1'b1; reset_n = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!frame_start && cyc < 40);
    check("first frame_start seen", int'(frame_start), 1);
    period = 0;
    do begin
      @(posedge clk); #1; period++;
      if (an == 2'b00) check("an both low", int'(an), 3);
    end while (!frame_start && period < 40);
    check("frame period", period, ND * (DC + BC));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
